pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the CPU core. It replaces the hand-written per-stage latches such as ID/EX and EX/MEM.
- Carries an opaque payload bus plus a valid bit.
- Handles pass, hold, bubble insertion and flush from the global stall vector and a flush line.
- Keeps saturating bubble and stall-cycle counters for pipeline performance debug.

Parameters:
- DATA_W, 32, payload width in bits (the concatenated control and data fields of the stage).
- STALL_W, 6, width of the global stall vector.
- STAGE, 2, index of this register's upstream stage in the stall vector. Must satisfy STAGE+1 < STALL_W.
- BUBBLE_VAL, 0, payload value loaded on reset, bubble or flush (a NOP encoding with write disabled).
- CNT_W, 16, width of each performance counter.

Ports:
- clk, input, 1, pipeline clock, rising edge.
- rst, input, 1, reset. Asynchronous, active-high.
- stall, input, STALL_W, global stall vector. 1 = Stop, 0 = NoStop.
- flush, input, 1, synchronous flush (exception or branch squash), active-high.
- valid_i, input, 1, upstream payload is a real instruction.
- data_i, input, DATA_W, upstream payload.
- valid_o, output, 1, registered valid.
- data_o, output, DATA_W, registered payload.
- held_o, output, 1, registered; 1 if the last edge was a hold.
- bubble_cnt_o, output, CNT_W, count of bubbles inserted by stall. Saturating.
- stall_cnt_o, output, CNT_W, count of hold cycles. Saturating.
- cnt_clr, input, 1, synchronous clear of both counters.

Behaviour:
- Reset: while rst=1, asynchronously and immediately set valid_o=0, data_o=BUBBLE_VAL, held_o=0, bubble_cnt_o=0, stall_cnt_o=0. On deassertion, the first action takes effect at the next rising edge.
- Let up = stall[STAGE] and dn = stall[STAGE+1]. At each rising edge, evaluate the following in strict priority order:
  1. flush=1: valid_o=0, data_o=BUBBLE_VAL, held_o=0. Flush beats any stall state, including hold; no counter increments.
  2. up=1, dn=0 (BUBBLE): valid_o=0, data_o=BUBBLE_VAL, held_o=0, bubble_cnt_o+=1.
  3. up=1, dn=1 (HOLD): data_o and valid_o are unchanged, held_o=1, stall_cnt_o+=1.
  4. up=0 (PASS): valid_o=valid_i, data_o=data_i, held_o=0. This applies regardless of dn; an upstream NoStop with a downstream Stop is illegal in the stall controller, and the block simply passes.
- Latency: exactly 1 cycle from data_i to data_o in PASS.
- Bubble values: data_o is forced to BUBBLE_VAL whenever valid_o is forced to 0. A PASS with valid_i=0 still copies data_i verbatim.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr=1 zeroes both counters at the edge. It takes priority over an increment in the same cycle, and it does not affect the data path.
  - Counters are not reset by flush.
- Stall bits other than STAGE and STAGE+1 are ignored.
- If reset asserts mid-hold, the outputs take reset values immediately and the hold state is lost.
- All output state lives in flops; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: assert rst mid-cycle with valid_o=1 and data_o=0x1234_5678 -> outputs drop without waiting for clk to valid_o=0, data_o=BUBBLE_VAL, both counters 0.
- Pass: stall=6'b000000, feed valid_i=1 with data_i=0xA0,0xA1,0xA2 on consecutive edges -> data_o shows 0xA0,0xA1,0xA2 one cycle later each, valid_o=1, held_o=0.
- Hold and bubble: with data_o=0xA1, apply stall=6'b001100 for 3 edges, then 6'b000100 for 1 edge, then 6'b000000:
  - hold phase: data_o stays 0xA1 and held_o=1 for 3 cycles, stall_cnt_o=3;
  - bubble edge: valid_o=0, data_o=BUBBLE_VAL, bubble_cnt_o=1;
  - release: the next data_i is passed.
- Flush priority: stall=6'b001100 together with flush=1 -> valid_o=0, data_o=BUBBLE_VAL, held_o=0, stall_cnt_o unchanged.
- Counter saturation and clear: with CNT_W=3, hold for 10 edges -> stall_cnt_o reaches 7 and stays 7. Then cnt_clr=1 together with a hold -> stall_cnt_o=0.
- Parametrisation: instantiate DATA_W=72, STAGE=3, BUBBLE_VAL=72'h1 -> stall[3]=1 with stall[4]=0 bubbles to 72'h1; stall[2]=1 alone has no effect.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with pass/hold/bubble/flush
// and saturating bubble/stall counters for pipeline debug.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        STALL_W    = 6,
  parameter int unsigned        STAGE      = 2,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               cnt_clr,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               held_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    OP_PASS,
    OP_BUBBLE,
    OP_HOLD,
    OP_FLUSH
  } op_e;

  op_e  op;
  logic up;
  logic dn;
  logic stall_unused;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Only our two neighbouring stall bits matter.
  assign stall_unused = ^stall;

  // Decode this edge's action; flush wins over every stall state.
  always_comb begin
    op = OP_PASS;
    unique case (1'b1)
      flush:               op = OP_FLUSH;
      !flush && up && !dn: op = OP_BUBBLE;
      !flush && up && dn:  op = OP_HOLD;
      !flush && !up:       op = OP_PASS;
      default:             op = OP_PASS;
    endcase
  end

  // Payload, valid and hold-indicator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= BUBBLE_VAL;
      held_o  <= 1'b0;
    end else begin
      case (op)
        OP_FLUSH, OP_BUBBLE: begin
          valid_o <= 1'b0;
          data_o  <= BUBBLE_VAL;
          held_o  <= 1'b0;
        end
        OP_HOLD: begin
          held_o  <= 1'b1;
        end
        default: begin
          valid_o <= valid_i;
          data_o  <= data_i;
          held_o  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating counters; clear beats increment, flush leaves them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else if (cnt_clr) begin
      bubble_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (op == OP_BUBBLE && bubble_cnt_o != '1)
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      if (op == OP_HOLD && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed plan steps, then random traffic,
// two instances (32-bit/stage 2/3-bit counters and 72-bit/stage 3).
module tb_pipe_stage_reg;

  localparam logic [31:0] BV0 = 32'h0000_0013;
  localparam logic [71:0] BV1 = 72'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        valid_i;
  logic [71:0] data_i;
  logic        cnt_clr;

  logic        v0, h0;
  logic [31:0] d0;
  logic [2:0]  b0, s0;
  logic        v1, h1;
  logic [71:0] d1;
  logic [15:0] b1, s1;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state, one slot per instance
  logic        mv [2];
  logic [71:0] md [2];
  logic        mh [2];
  int          mb [2];
  int          ms [2];
  int          stg [2];
  int          cmax [2];
  logic [71:0] bval [2];
  logic [71:0] msk [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .STALL_W(6), .STAGE(2),
    .BUBBLE_VAL(BV0), .CNT_W(3)
  ) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_i(valid_i), .data_i(data_i[31:0]), .cnt_clr(cnt_clr),
    .valid_o(v0), .data_o(d0), .held_o(h0),
    .bubble_cnt_o(b0), .stall_cnt_o(s0)
  );

  pipe_stage_reg #(
    .DATA_W(72), .STALL_W(6), .STAGE(3),
    .BUBBLE_VAL(BV1), .CNT_W(16)
  ) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_i(valid_i), .data_i(data_i), .cnt_clr(cnt_clr),
    .valid_o(v1), .data_o(d1), .held_o(h1),
    .bubble_cnt_o(b1), .stall_cnt_o(s1)
  );

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0;
      md[k] = bval[k];
      mh[k] = 1'b0;
      mb[k] = 0;
      ms[k] = 0;
    end
  endtask

  // One rising edge worth of the behavioural rules.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic u, d;
      u = stall[stg[k]];
      d = stall[stg[k] + 1];
      if (flush) begin
        mv[k] = 1'b0; md[k] = bval[k]; mh[k] = 1'b0;
      end else if (u && !d) begin
        mv[k] = 1'b0; md[k] = bval[k]; mh[k] = 1'b0;
        if (mb[k] < cmax[k]) mb[k]++;
      end else if (u) begin
        mh[k] = 1'b1;
        if (ms[k] < cmax[k]) ms[k]++;
      end else begin
        mv[k] = valid_i; md[k] = data_i & msk[k]; mh[k] = 1'b0;
      end
      if (cnt_clr) begin
        mb[k] = 0; ms[k] = 0;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".v0"}, 72'(v0), 72'(mv[0]));
    chk({tag, ".d0"}, 72'(d0), md[0]);
    chk({tag, ".h0"}, 72'(h0), 72'(mh[0]));
    chk({tag, ".b0"}, 72'(b0), 72'(mb[0]));
    chk({tag, ".s0"}, 72'(s0), 72'(ms[0]));
    chk({tag, ".v1"}, 72'(v1), 72'(mv[1]));
    chk({tag, ".d1"}, d1, md[1]);
    chk({tag, ".h1"}, 72'(h1), 72'(mh[1]));
    chk({tag, ".b1"}, 72'(b1), 72'(mb[1]));
    chk({tag, ".s1"}, 72'(s1), 72'(ms[1]));
  endtask

  task automatic drive(logic [5:0] st, logic fl, logic vi,
                       logic [71:0] di, logic cc);
    stall   = st;
    flush   = fl;
    valid_i = vi;
    data_i  = di;
    cnt_clr = cc;
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    stg[0] = 2;  stg[1] = 3;
    cmax[0] = 7; cmax[1] = 65535;
    bval[0] = 72'(BV0); bval[1] = BV1;
    msk[0] = 72'hFFFF_FFFF; msk[1] = '1;

    rst = 1'b1;
    drive(6'b000000, 1'b0, 1'b0, 72'h0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // pass: one-cycle latency
    drive(6'b000000, 1'b0, 1'b1, 72'hA0, 1'b0);
    step("pass0");
    chk("pass0.data", 72'(d0), 72'hA0);
    drive(6'b000000, 1'b0, 1'b1, 72'hA1, 1'b0);
    step("pass1");
    drive(6'b000000, 1'b0, 1'b1, 72'hA2, 1'b0);
    step("pass2");
    chk("pass2.data", 72'(d0), 72'hA2);
    drive(6'b000000, 1'b0, 1'b1, 72'hA1, 1'b0);
    step("pass3");

    // hold for 3 edges
    for (int i = 0; i < 3; i++) begin
      drive(6'b001100, 1'b0, 1'b1, 72'hC0 + 72'(i), 1'b0);
      step("hold");
      chk("hold.data", 72'(d0), 72'hA1);
      chk("hold.held", 72'(h0), 72'h1);
    end
    chk("hold.scnt", 72'(s0), 72'h3);

    // bubble edge
    drive(6'b000100, 1'b0, 1'b1, 72'hD0, 1'b0);
    step("bubble");
    chk("bubble.valid", 72'(v0), 72'h0);
    chk("bubble.data", 72'(d0), 72'(BV0));
    chk("bubble.bcnt", 72'(b0), 72'h1);

    // release
    drive(6'b000000, 1'b0, 1'b1, 72'hB5, 1'b0);
    step("release");
    chk("release.data", 72'(d0), 72'hB5);

    // flush beats hold
    drive(6'b001100, 1'b1, 1'b1, 72'hE0, 1'b0);
    step("flush");
    chk("flush.data", 72'(d0), 72'(BV0));
    chk("flush.held", 72'(h0), 72'h0);
    chk("flush.scnt", 72'(s0), 72'h3);

    // saturation then clear
    for (int i = 0; i < 10; i++) begin
      drive(6'b001100, 1'b0, 1'b0, 72'h0, 1'b0);
      step("sat");
    end
    chk("sat.scnt", 72'(s0), 72'h7);
    drive(6'b001100, 1'b0, 1'b0, 72'h0, 1'b1);
    step("clr");
    chk("clr.scnt", 72'(s0), 72'h0);

    // wide instance at stage 3
    drive(6'b000000, 1'b0, 1'b1, 72'hAB_0000_0000_0000_0042, 1'b0);
    step("w.pass");
    drive(6'b001000, 1'b0, 1'b1, 72'h55, 1'b0);
    step("w.bubble");
    chk("w.bubble.data", d1, 72'h1);
    chk("w.bubble.valid", 72'(v1), 72'h0);
    drive(6'b000100, 1'b0, 1'b1, 72'hFE_DCBA_9876_5432_10FF, 1'b0);
    step("w.other");
    chk("w.other.data", d1, 72'hFE_DCBA_9876_5432_10FF);

    // async reset mid-hold
    drive(6'b000000, 1'b0, 1'b1, 72'h1234_5678, 1'b0);
    step("pre_rst");
    drive(6'b001100, 1'b0, 1'b0, 72'h0, 1'b0);
    step("pre_rst_hold");
    chk("pre_rst.data", 72'(d0), 72'h1234_5678);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(6'($urandom_range(0, 63)),
            ($urandom_range(0, 9) == 0),
            1'($urandom()),
            72'({$urandom(), $urandom(), $urandom()}),
            ($urandom_range(0, 39) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
